// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared modes, FSM states and frame constants for the ADC SPI sequencer
package adc_spi_pkg;
  localparam int AXIS_W = 32;
  localparam int REG_FRAME_BITS = 24;
  localparam logic [2:0] READ_MODE_PREFIX = 3'b101;
  localparam logic [23:0] EXIT_FRAME = {1'b0, 15'h0014, 8'h01};
  typedef enum logic [1:0] {MODE_CONV = 2'b00, MODE_REG_ONCE = 2'b01, MODE_REG = 2'b11} mode_e;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;
endpackage

// File: rtl/adc_spi_sequencer_if.sv
// adc_spi_sequencer_if: AXI-Stream bundle (tdata/tuser/tvalid/tready) with master and slave views
interface adc_spi_sequencer_if;
  import adc_spi_pkg::*;
  logic [AXIS_W-1:0] tdata;
  logic tuser, tvalid, tready;
  modport master (output tdata, tuser, tvalid, input tready);
  modport slave (input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/adc_sck_gen.sv
// adc_sck_gen: SCK divider; en_i runs it, sck_o idles low, rise_o/fall_o mark the aclk edge where sck_o toggles
module adc_sck_gen #(
  parameter int SCK_DIV = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = SCK_DIV > 1 ? $clog2(SCK_DIV) : 1;
  logic [CW-1:0] cnt_q;
  logic tc;
  assign tc = en_i && cnt_q == CW'(SCK_DIV - 1);
  assign rise_o = tc && !sck_o;
  assign fall_o = tc && sck_o;
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      cnt_q <= '0;
      sck_o <= 1'b0;
    end else begin
      cnt_q <= (!en_i || tc) ? '0 : cnt_q + 1'b1;
      sck_o <= en_i && (sck_o ^ tc);
    end
endmodule

// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: SPI master for SAR ADCs; trigger->conversion frame, s_axis->24-bit register frame, results on m_axis, flags on status
module adc_spi_sequencer
  import adc_spi_pkg::*;
#(
  parameter int NUM_SDI    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SCK_DIV    = 2,
  parameter int CSN_SETUP  = 2,
  parameter int CSN_HOLD   = 2
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               trigger,
  input  logic               clear_flags,
  input  logic [NUM_SDI-1:0] spi_sdi,
  output logic               spi_sdo,
  output logic               spi_csn,
  output logic               spi_sck,
  output logic               spi_resetn,
  adc_spi_sequencer_if.slave  s_axis,
  adc_spi_sequencer_if.master m_axis,
  output logic [31:0]        status,
  output logic               ready
);
  localparam int CONV_BITS = DATA_WIDTH / NUM_SDI;
  state_e state_q;
  mode_e mode_q, mode_d;
  logic [23:0] frame_q, tx_q;
  logic [31:0] acc_q, tdata_q;
  logic [15:0] cnt_q;
  logic [5:0] bit_q;
  logic reg_pending_q, is_reg_q, csn_q, sdo_q, tvalid_q, tuser_q, overflow_q, trig_ovr_q;
  logic rise, fall, accept, start_conv, last_bit, hold_done, out_load, unused_s_axis;
  adc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck (
    .aclk(aclk), .areset(areset), .en_i(state_q == SHIFT),
    .sck_o(spi_sck), .rise_o(rise), .fall_o(fall)
  );
  assign ready = state_q == IDLE && !reg_pending_q;
  assign s_axis.tready = ready;
  assign accept = s_axis.tvalid && ready;
  assign start_conv = mode_q == MODE_CONV && trigger;
  assign last_bit = fall && bit_q == (is_reg_q ? 6'(REG_FRAME_BITS - 1) : 6'(CONV_BITS - 1));
  assign hold_done = state_q == HOLD && cnt_q == 16'(CSN_HOLD - 1);
  // Write frames (bit 23 clear) complete silently; only conversions and reads emit a beat.
  assign out_load = hold_done && (!is_reg_q || frame_q[23]);
  // A read-prefix frame always lands in sticky REG; otherwise one-shot mode or the exit frame drop back to CONV.
  assign mode_d = frame_q[23:21] == READ_MODE_PREFIX ? MODE_REG :
                  (mode_q == MODE_REG_ONCE || frame_q == EXIT_FRAME) ? MODE_CONV : mode_q;
  assign unused_s_axis = ^{s_axis.tdata[31:24], s_axis.tuser};
  assign spi_csn = csn_q;
  assign spi_sdo = sdo_q;
  assign spi_resetn = ~areset;
  assign m_axis.tdata = tdata_q;
  assign m_axis.tuser = tuser_q;
  assign m_axis.tvalid = tvalid_q;
  assign status = {frame_q, 1'b0, trig_ovr_q, overflow_q, tvalid_q, mode_q, reg_pending_q, state_q != IDLE};
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state_q <= IDLE;
      mode_q <= MODE_CONV;
      frame_q <= '0;
      tx_q <= '0;
      acc_q <= '0;
      tdata_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      reg_pending_q <= 1'b0;
      is_reg_q <= 1'b0;
      csn_q <= 1'b1;
      sdo_q <= 1'b0;
      tvalid_q <= 1'b0;
      tuser_q <= 1'b0;
      overflow_q <= 1'b0;
      trig_ovr_q <= 1'b0;
    end else begin
      if (accept) begin
        frame_q <= s_axis.tdata[23:0];
        reg_pending_q <= 1'b1;
        if (mode_q != MODE_REG) mode_q <= MODE_REG_ONCE;
      end
      case (state_q)
        IDLE: if (start_conv || reg_pending_q) begin
          state_q <= SETUP;
          csn_q <= 1'b0;
          cnt_q <= '0;
          bit_q <= '0;
          acc_q <= '0;
          is_reg_q <= !start_conv;
          if (!start_conv) reg_pending_q <= 1'b0;
          sdo_q <= !start_conv && frame_q[23];
          tx_q <= start_conv ? '0 : {frame_q[22:0], 1'b0};
        end
        SETUP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == 16'(CSN_SETUP - 1)) begin
            state_q <= SHIFT;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (rise) acc_q <= is_reg_q ? {acc_q[30:0], spi_sdi[0]} : {acc_q[31-NUM_SDI:0], spi_sdi};
          if (fall) begin
            sdo_q <= tx_q[23];
            tx_q <= tx_q << 1;
            bit_q <= bit_q + 1'b1;
          end
          if (last_bit) state_q <= HOLD;
        end
        HOLD: begin
          cnt_q <= cnt_q + 1'b1;
          if (hold_done) begin
            csn_q <= 1'b1;
            state_q <= IDLE;
            if (is_reg_q) mode_q <= mode_d;
          end
        end
      endcase
      if (out_load) begin
        tdata_q <= is_reg_q ? {24'b0, acc_q[7:0]} : acc_q;
        tuser_q <= is_reg_q;
        tvalid_q <= 1'b1;
      end else if (m_axis.tready) tvalid_q <= 1'b0;
      overflow_q <= (out_load && tvalid_q && !m_axis.tready) || (overflow_q && !clear_flags);
      trig_ovr_q <= (trigger && state_q != IDLE && mode_q == MODE_CONV) || (trig_ovr_q && !clear_flags);
    end
endmodule

// File: tb/tb_adc_spi_sequencer.sv
// tb_adc_spi_sequencer: directed scoreboard bench for adc_spi_sequencer with an SDI responder and SPI/AXIS monitors
module tb_adc_spi_sequencer;
  logic aclk = 1'b0, areset = 1'b1, trigger = 1'b0, clear_flags = 1'b0;
  logic [3:0] spi_sdi;
  logic spi_sdo, spi_csn, spi_sck, spi_resetn, ready;
  logic [31:0] status;
  logic [3:0] resp [24];
  logic [23:0] sdo_cap = '0;
  logic [32:0] exp_q [$];
  logic [32:0] obs_q [$];
  int tests = 0, fails = 0, rd = 0;
  int beats = 0, csn_low = 0, rises = 0, fall_cnt = 0, base = 0;
  int b0, r0, c0;
  adc_spi_sequencer_if s_axis();
  adc_spi_sequencer_if m_axis();
  adc_spi_sequencer #(.NUM_SDI(4), .DATA_WIDTH(16), .SCK_DIV(2), .CSN_SETUP(2), .CSN_HOLD(2)) dut (
    .aclk(aclk), .areset(areset), .trigger(trigger), .clear_flags(clear_flags),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo), .spi_csn(spi_csn), .spi_sck(spi_sck),
    .spi_resetn(spi_resetn), .s_axis(s_axis), .m_axis(m_axis), .status(status), .ready(ready)
  );
  always #5 aclk = ~aclk;
  // ADC model: lane nibble k of resp[] is presented after the k-th falling SCK edge of the frame.
  always @(negedge spi_csn) base = fall_cnt;
  always @(negedge spi_sck) fall_cnt++;
  always_comb spi_sdi = resp[(fall_cnt - base) > 23 ? 23 : (fall_cnt - base)];
  always @(posedge spi_sck) begin
    rises++;
    sdo_cap = {sdo_cap[22:0], spi_sdo};
  end
  always @(negedge aclk) begin
    if (!spi_csn) csn_low++;
    if (m_axis.tvalid && m_axis.tready) begin
      obs_q.push_back({m_axis.tuser, m_axis.tdata});
      beats++;
    end
  end
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask
  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 50 && spi_csn; i++) tick();
    chk({tag, "_csn_fall"}, 64'(spi_csn), 64'd0);
    for (int i = 0; i < 500 && !spi_csn; i++) tick();
    chk({tag, "_csn_rise"}, 64'(spi_csn), 64'd1);
    repeat (3) tick();
  endtask
  task automatic send_word(input string tag, input logic [23:0] w);
    logic ok;
    ok = 1'b0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata = {8'h00, w};
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = s_axis.tready;
      tick();
    end
    s_axis.tvalid = 1'b0;
    chk({tag, "_accept"}, 64'(ok), 64'd1);
  endtask
  task automatic get_beat(input string tag);
    logic [32:0] e;
    for (int i = 0; i < 100 && obs_q.size() <= rd; i++) tick();
    chk({tag, "_present"}, 64'(obs_q.size() > rd), 64'd1);
    if (obs_q.size() > rd) begin
      e = exp_q.pop_front();
      chk(tag, 64'(obs_q[rd]), 64'(e));
      rd++;
    end
  endtask
  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata = '0;
    s_axis.tuser = 1'b0;
    m_axis.tready = 1'b1;
    foreach (resp[i]) resp[i] = 4'h0;
    resp[0] = 4'hA; resp[1] = 4'hB; resp[2] = 4'hC; resp[3] = 4'hD;
    resp[16] = 4'h0; resp[17] = 4'h1; resp[18] = 4'h0; resp[19] = 4'h1;
    resp[20] = 4'h1; resp[21] = 4'h0; resp[22] = 4'h1; resp[23] = 4'h0;
    repeat (3) tick();
    chk("rst_resetn_low", 64'(spi_resetn), 64'd0);
    areset = 1'b0;
    tick();
    chk("rst_csn", 64'(spi_csn), 64'd1);
    chk("rst_sck", 64'(spi_sck), 64'd0);
    chk("rst_sdo", 64'(spi_sdo), 64'd0);
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis.tdata), 64'd0);
    chk("rst_tuser", 64'(m_axis.tuser), 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_resetn_high", 64'(spi_resetn), 64'd1);
    // conversion frame
    c0 = csn_low; r0 = rises;
    exp_q.push_back({1'b0, 32'h0000ABCD});
    pulse_trigger();
    wait_done("conv");
    chk("conv_csn_cycles", 64'(csn_low - c0), 64'd20);
    chk("conv_rises", 64'(rises - r0), 64'd4);
    get_beat("conv_beat");
    tick();
    chk("conv_tvalid_drop", 64'(status[4]), 64'd0);
    // register write in CONV
    b0 = beats; r0 = rises;
    send_word("wr", 24'h001401);
    chk("wr_mode_once", 64'(status[3:2]), 64'd1);
    wait_done("wr");
    chk("wr_rises", 64'(rises - r0), 64'd24);
    chk("wr_sdo", 64'(sdo_cap), 64'h001401);
    chk("wr_sdo_idle", 64'(spi_sdo), 64'd0);
    chk("wr_no_beat", 64'(beats - b0), 64'd0);
    chk("wr_mode", 64'(status[3:2]), 64'd0);
    chk("wr_latched", 64'(status[31:8]), 64'h001401);
    // sticky REG mode and read-back
    exp_q.push_back({1'b1, 32'h0000005A});
    send_word("sticky", 24'hA00000);
    wait_done("sticky");
    get_beat("sticky_beat");
    chk("sticky_mode", 64'(status[3:2]), 64'd3);
    exp_q.push_back({1'b1, 32'h0000005A});
    send_word("rd", 24'h800A00);
    wait_done("rd");
    get_beat("rd_beat");
    chk("rd_mode", 64'(status[3:2]), 64'd3);
    chk("rd_latched", 64'(status[31:8]), 64'h800A00);
    b0 = beats;
    send_word("exit", 24'h001401);
    wait_done("exit");
    chk("exit_mode", 64'(status[3:2]), 64'd0);
    chk("exit_no_beat", 64'(beats - b0), 64'd0);
    // overflow: two conversions with the sink stalled
    m_axis.tready = 1'b0;
    b0 = beats;
    pulse_trigger();
    wait_done("ovf1");
    chk("ovf_first_no_flag", 64'(status[5]), 64'd0);
    resp[0] = 4'h1; resp[1] = 4'h2; resp[2] = 4'h3; resp[3] = 4'h4;
    pulse_trigger();
    wait_done("ovf2");
    chk("ovf_flag", 64'(status[5]), 64'd1);
    chk("ovf_tvalid", 64'(status[4]), 64'd1);
    chk("ovf_tdata", 64'(m_axis.tdata), 64'h00001234);
    pulse_clear();
    chk("ovf_cleared", 64'(status[5]), 64'd0);
    exp_q.push_back({1'b0, 32'h00001234});
    m_axis.tready = 1'b1;
    get_beat("ovf_beat");
    chk("ovf_one_beat", 64'(beats - b0), 64'd1);
    // trigger overrun
    b0 = beats;
    exp_q.push_back({1'b0, 32'h00001234});
    pulse_trigger();
    repeat (6) tick();
    chk("ovr_pre", 64'(status[6]), 64'd0);
    pulse_trigger();
    chk("ovr_flag", 64'(status[6]), 64'd1);
    wait_done("ovr");
    repeat (10) tick();
    chk("ovr_idle", 64'(status[0]), 64'd0);
    get_beat("ovr_beat");
    chk("ovr_one_beat", 64'(beats - b0), 64'd1);
    pulse_clear();
    chk("ovr_cleared", 64'(status[6]), 64'd0);
    // trigger and s_axis in the same IDLE cycle: conversion goes first
    exp_q.push_back({1'b0, 32'h00001234});
    exp_q.push_back({1'b1, 32'h0000005A});
    trigger = 1'b1;
    s_axis.tvalid = 1'b1;
    s_axis.tdata = 32'h00800A00;
    chk("prio_ready", 64'(ready), 64'd1);
    tick();
    trigger = 1'b0;
    s_axis.tvalid = 1'b0;
    chk("prio_pending", 64'(status[1]), 64'd1);
    wait_done("prio_conv");
    wait_done("prio_reg");
    get_beat("prio_first");
    get_beat("prio_second");
    chk("prio_mode", 64'(status[3:2]), 64'd0);
    // reset in the middle of SHIFT
    b0 = beats;
    pulse_trigger();
    repeat (8) tick();
    chk("mid_in_frame", 64'(spi_csn), 64'd0);
    areset = 1'b1;
    #1;
    chk("mid_csn", 64'(spi_csn), 64'd1);
    chk("mid_sck", 64'(spi_sck), 64'd0);
    chk("mid_status", 64'(status), 64'd0);
    tick();
    areset = 1'b0;
    repeat (40) tick();
    chk("mid_no_beat", 64'(beats - b0), 64'd0);
    chk("mid_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("mid_csn_idle", 64'(spi_csn), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
